// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter.
//   arb_state_e : FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   clog2       : index width helper, never returns less than 1
package mul_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side bus of the multiplier arbiter.
//   req/req_a/req_b          : per-requester request and packed operands
//   ack/resp_valid/resp_id   : one-cycle completion strobe and requester index
//   resp_data/resp_err       : product (held) and timeout flag
//   busy                     : arbiter is not idle
interface mul_arbiter_if
  import mul_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int C_WIDTH = 16,
  parameter int ID_W    = clog2(N_REQ)
) ();

  logic [N_REQ-1:0]         req;
  logic [N_REQ*C_WIDTH-1:0] req_a;
  logic [N_REQ*C_WIDTH-1:0] req_b;
  logic [N_REQ-1:0]         ack;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [C_WIDTH-1:0]       resp_data;
  logic                     resp_err;
  logic                     busy;

  modport master (
    output req, req_a, req_b,
    input  ack, resp_valid, resp_id, resp_data, resp_err, busy
  );

  modport slave (
    input  req, req_a, req_b,
    output ack, resp_valid, resp_id, resp_data, resp_err, busy
  );

endinterface

// File: rtl/mul_rr_pick.sv
// Combinational round-robin selector.
//   req_i : request vector
//   ptr_i : highest-priority index
//   gnt_o : first set request at or above ptr_i, wrapping
//   any_o : at least one request set
module mul_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  gnt_o,
  output logic             any_o
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req_i[ID_W'((int'(ptr_i) + off) % N_REQ)]) begin
        gnt_o = ID_W'((int'(ptr_i) + off) % N_REQ);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplier.sv
// Multi-cycle unsigned multiplier shared by the arbiter.
//   clk, reset (async, active-low)
//   trigger : start with a/b, accepted only while ready
//   y       : product (low half, or Q1.(C_WIDTH-1) when FIXED_POINT != 0)
//   done    : one-cycle pulse when y is valid
//   ready   : idle, can accept a trigger
// MUL_TYPE 3 is a serial shift-add (latency C_WIDTH+1); others use one
// registered full multiply (latency 1).
module multiplier #(
  parameter int C_WIDTH     = 16,
  parameter int FIXED_POINT = 0,
  parameter int MUL_TYPE    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  output logic [C_WIDTH-1:0] y,
  output logic               done,
  output logic               ready
);

  localparam int P_W   = 2 * C_WIDTH;
  localparam int CNT_W = $clog2(C_WIDTH + 1);

  logic [P_W-1:0]     acc_q, mcand_q, acc_d;
  logic [C_WIDTH-1:0] mplier_q, y_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q, done_q;

  function automatic logic [C_WIDTH-1:0] scale(input logic [P_W-1:0] p);
    if (FIXED_POINT != 0) return p[P_W-2 -: C_WIDTH];
    else                  return p[C_WIDTH-1:0];
  endfunction

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      y_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (run_q) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
          y_q    <= scale(acc_d);
        end
      end else if (trigger) begin
        if (MUL_TYPE == 3) begin
          acc_q    <= '0;
          mcand_q  <= {{C_WIDTH{1'b0}}, a};
          mplier_q <= b;
          cnt_q    <= CNT_W'(C_WIDTH);
          run_q    <= 1'b1;
        end else begin
          done_q <= 1'b1;
          y_q    <= scale(P_W'(a) * P_W'(b));
        end
      end
    end
  end

  assign y     = y_q;
  assign done  = done_q;
  assign ready = ~run_q;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multiplier among N_REQ requesters.
//   ctl_clk : clock
//   reset   : async, active-low; also resets the multiplier
//   bus     : requester bus (slave side), see mul_arbiter_if
// All bus outputs are registered.
//
// state | meaning
// IDLE  | wait for a request while the multiplier is ready; latch grant and operands
// ISSUE | trigger high for this one cycle; watchdog cleared
// WAIT  | wait for done, or abort after TIMEOUT cycles
// RESP  | ack/resp_valid high; pointer moves past the grant
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int C_WIDTH     = 16,
  parameter int FIXED_POINT = 0,
  parameter int MUL_TYPE    = 3,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic        ctl_clk,
  input  logic        reset,
  mul_arbiter_if.slave bus
);

  localparam int ID_W  = clog2(N_REQ);
  localparam int CNT_W = clog2(TIMEOUT);

  arb_state_e         state_q;
  logic [ID_W-1:0]    ptr_q, gnt_q, pick_gnt, id_q;
  logic               pick_any;
  logic [C_WIDTH-1:0] op_a_q, op_b_q, sel_a, sel_b, data_q, mul_y;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_REQ-1:0]   ack_q;
  logic               trig_q, valid_q, err_q, busy_q;
  logic               mul_done, mul_ready;

  mul_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt == ID_W'(i)) begin
        sel_a = bus.req_a[i*C_WIDTH +: C_WIDTH];
        sel_b = bus.req_b[i*C_WIDTH +: C_WIDTH];
      end
    end
  end

  multiplier #(
    .C_WIDTH     (C_WIDTH),
    .FIXED_POINT (FIXED_POINT),
    .MUL_TYPE    (MUL_TYPE)
  ) u_mul (
    .clk     (ctl_clk),
    .reset   (reset),
    .trigger (trig_q),
    .a       (op_a_q),
    .b       (op_b_q),
    .y       (mul_y),
    .done    (mul_done),
    .ready   (mul_ready)
  );

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any && mul_ready) begin
            gnt_q   <= pick_gnt;
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          trig_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // done wins over the watchdog when both land on the last cycle
          if (mul_done || cnt_q == CNT_W'(TIMEOUT - 1)) begin
            data_q  <= mul_done ? mul_y : '0;
            err_q   <= ~mul_done;
            ack_q   <= N_REQ'(1) << gnt_q;
            valid_q <= 1'b1;
            id_q    <= gnt_q;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          ack_q   <= '0;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_arbiter_if #(.N_REQ(N), .C_WIDTH(W)) bus ();
  mul_arbiter_if #(.N_REQ(N), .C_WIDTH(W)) bus_to ();

  mul_arbiter #(.C_WIDTH(W), .FIXED_POINT(0), .MUL_TYPE(3), .N_REQ(N), .TIMEOUT(64)) dut (
    .ctl_clk (clk), .reset (rst_n), .bus (bus.slave));

  mul_arbiter #(.C_WIDTH(W), .FIXED_POINT(0), .MUL_TYPE(3), .N_REQ(N), .TIMEOUT(TO)) dut_to (
    .ctl_clk (clk), .reset (rst_n), .bus (bus_to.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int lat_l    = -1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] prod8(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = (int'(a) * int'(b)) % 256;
    return 8'(p);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.resp_valid); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.resp_err); end
    n_checks++; if (bus.resp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", bus.resp_data); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (dut.trig_q !== 1'b0) begin n_fail++; $display("FAIL reset_trigger got=%b exp=0", dut.trig_q); end
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single();
    int c_trig, c_done, c_ack, n_trig;
    c_trig = -1; c_done = -1; c_ack = -1; n_trig = 0;
    bus.req_a[7:0] = 8'h03;
    bus.req_b[7:0] = 8'h02;
    bus.req = 4'b0001;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (dut.trig_q) begin n_trig++; if (c_trig < 0) c_trig = c; end
      if (dut.mul_done && c_trig >= 0 && c_done < 0) c_done = c;
      if (bus.resp_valid) begin c_ack = c; break; end
    end
    lat_l = c_done - c_trig;
    n_checks++; if (c_ack < 0) begin n_fail++; $display("FAIL single_ack_seen got=none exp=ack within 60 cycles"); end
    n_checks++; if (c_trig !== 1) begin n_fail++; $display("FAIL single_trigger_cycle got=%0d exp=1", c_trig); end
    n_checks++; if (lat_l < 1) begin n_fail++; $display("FAIL single_latency_L got=%0d exp>=1", lat_l); end
    n_checks++; if (c_ack !== lat_l + 2) begin n_fail++; $display("FAIL single_grant_to_ack got=%0d exp=%0d", c_ack, lat_l + 2); end
    n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b exp=0001", bus.ack); end
    n_checks++; if (bus.resp_id !== 2'd0) begin n_fail++; $display("FAIL single_id got=%0d exp=0", bus.resp_id); end
    n_checks++; if (bus.resp_data !== 8'h06) begin n_fail++; $display("FAIL single_data got=%h exp=06", bus.resp_data); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b exp=0", bus.resp_err); end
    bus.req = 4'b0000;
    tick();
    if (dut.trig_q) n_trig++;
    n_checks++; if (n_trig !== 1) begin n_fail++; $display("FAIL single_trigger_count got=%0d exp=1", n_trig); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_pulse got=%b exp=0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 8'h06) begin n_fail++; $display("FAIL single_data_held got=%h exp=06", bus.resp_data); end
  endtask

  task automatic test_contention();
    int exp_order [5];
    int got, last_c, re_raise;
    logic [3:0] exp_ack;
    exp_order = '{0, 1, 2, 3, 0};
    got = 0; last_c = -1; re_raise = -1;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = 8'h05;
      bus.req_b[i*W +: W] = 8'h07;
    end
    bus.req = 4'b1111;
    for (int c = 1; c <= 200 && got < 5; c++) begin
      tick();
      if (re_raise >= 0) begin bus.req[re_raise] = 1'b1; re_raise = -1; end
      if (bus.resp_valid) begin
        exp_ack = 4'b0001 << exp_order[got];
        n_checks++; if (bus.resp_id !== 2'(exp_order[got])) begin n_fail++; $display("FAIL contention_id[%0d] got=%0d exp=%0d", got, bus.resp_id, exp_order[got]); end
        n_checks++; if (bus.ack !== exp_ack) begin n_fail++; $display("FAIL contention_ack[%0d] got=%b exp=%b", got, bus.ack, exp_ack); end
        n_checks++; if (bus.resp_data !== 8'h23) begin n_fail++; $display("FAIL contention_data[%0d] got=%h exp=23", got, bus.resp_data); end
        if (last_c >= 0) begin
          n_checks++; if (c - last_c !== lat_l + 3) begin n_fail++; $display("FAIL contention_spacing[%0d] got=%0d exp=%0d", got, c - last_c, lat_l + 3); end
        end
        last_c = c;
        bus.req[exp_order[got]] = 1'b0;
        re_raise = exp_order[got];
        got++;
      end
    end
    bus.req = 4'b0000;
    n_checks++; if (got !== 5) begin n_fail++; $display("FAIL contention_ack_count got=%0d exp=5", got); end
    tick(); tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL contention_drain_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_withdraw();
    int ids [$];
    logic [7:0] a0, b0, a1, b1;
    apply_reset();
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    bus.req_a[0 +: W] = a0; bus.req_b[0 +: W] = b0;
    bus.req = 4'b0001;
    tick(); tick(); tick();
    bus.req_a[W +: W] = a1; bus.req_b[W +: W] = b1;
    bus.req_a[2*W +: W] = 8'($urandom); bus.req_b[2*W +: W] = 8'($urandom);
    bus.req[1] = 1'b1;
    bus.req[2] = 1'b1;
    tick(); tick();
    bus.req[2] = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.resp_valid) begin
        ids.push_back(int'(bus.resp_id));
        if (ids.size() == 1) begin
          n_checks++; if (bus.resp_data !== prod8(a0, b0)) begin n_fail++; $display("FAIL withdraw_data0 got=%h exp=%h", bus.resp_data, prod8(a0, b0)); end
        end else if (ids.size() == 2) begin
          n_checks++; if (bus.resp_data !== prod8(a1, b1)) begin n_fail++; $display("FAIL withdraw_data1 got=%h exp=%h", bus.resp_data, prod8(a1, b1)); end
        end
        bus.req = bus.req & ~bus.ack;
      end
    end
    n_checks++; if (ids.size() !== 2) begin n_fail++; $display("FAIL withdraw_ack_count got=%0d exp=2", ids.size()); end
    if (ids.size() >= 2) begin
      n_checks++; if (ids[0] !== 0 || ids[1] !== 1) begin n_fail++; $display("FAIL withdraw_order got=%0d,%0d exp=0,1", ids[0], ids[1]); end
    end
    n_checks++; if (dut.ptr_q !== 2'd2) begin n_fail++; $display("FAIL withdraw_pointer got=%0d exp=2", dut.ptr_q); end
    bus.req = 4'b0000;
  endtask

  task automatic test_timeout();
    int c_ack, extra;
    c_ack = -1; extra = 0;
    bus_to.req_a[0 +: W] = 8'($urandom_range(1, 255));
    bus_to.req_b[0 +: W] = 8'($urandom_range(1, 255));
    bus_to.req = 4'b0001;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus_to.resp_valid) begin c_ack = c; break; end
    end
    n_checks++; if (c_ack !== TO + 2) begin n_fail++; $display("FAIL timeout_cycle got=%0d exp=%0d", c_ack, TO + 2); end
    n_checks++; if (bus_to.resp_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%b exp=1", bus_to.resp_err); end
    n_checks++; if (bus_to.resp_data !== 8'h00) begin n_fail++; $display("FAIL timeout_data got=%h exp=00", bus_to.resp_data); end
    n_checks++; if (bus_to.ack !== 4'b0001) begin n_fail++; $display("FAIL timeout_ack got=%b exp=0001", bus_to.ack); end
    n_checks++; if (bus_to.busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_resp got=%b exp=1", bus_to.busy); end
    bus_to.req = 4'b0000;
    tick();
    n_checks++; if (bus_to.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after got=%b exp=0", bus_to.busy); end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus_to.resp_valid) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL timeout_late_done got=%0d extra acks exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, b;
    int c_ack;
    bus.req_a[0 +: W] = 8'($urandom_range(1, 255));
    bus.req_b[0 +: W] = 8'($urandom_range(1, 255));
    bus.req = 4'b0001;
    tick(); tick(); tick(); tick();
    n_checks++; if (dut.state_q !== ST_WAIT) begin n_fail++; $display("FAIL rstmid_in_wait got=%0d exp=%0d", dut.state_q, ST_WAIT); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.ack !== 4'b0000) begin n_fail++; $display("FAIL rstmid_handshake got=busy %b valid %b ack %b exp=0 0 0000", bus.busy, bus.resp_valid, bus.ack); end
    n_checks++; if (bus.resp_data !== 8'h00 || bus.resp_id !== 2'd0 || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp got=data %h id %0d err %b exp=00 0 0", bus.resp_data, bus.resp_id, bus.resp_err); end
    n_checks++; if (dut.state_q !== ST_IDLE || dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL rstmid_state got=state %0d ptr %0d exp=0 0", dut.state_q, dut.ptr_q); end
    n_checks++; if (dut.trig_q !== 1'b0 || dut.op_a_q !== 8'h00) begin n_fail++; $display("FAIL rstmid_regs got=trig %b op_a %h exp=0 00", dut.trig_q, dut.op_a_q); end
    bus.req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    a = 8'($urandom); b = 8'($urandom);
    bus.req_a[0 +: W] = a; bus.req_b[0 +: W] = b;
    bus.req = 4'b0001;
    c_ack = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.resp_valid) begin c_ack = c; break; end
    end
    n_checks++; if (c_ack !== lat_l + 2) begin n_fail++; $display("FAIL rstmid_serve_latency got=%0d exp=%0d", c_ack, lat_l + 2); end
    n_checks++; if (bus.resp_id !== 2'd0 || bus.resp_data !== prod8(a, b)) begin n_fail++; $display("FAIL rstmid_serve got=id %0d data %h exp=0 %h", bus.resp_id, bus.resp_data, prod8(a, b)); end
    bus.req = 4'b0000;
    tick();
    n_checks++; if (dut.ptr_q !== 2'd1) begin n_fail++; $display("FAIL rstmid_pointer_after got=%0d exp=1", dut.ptr_q); end
  endtask

  // Scoreboard: the grant is predicted from the request vector that was on
  // the bus at the grant edge and the model pointer; products from the
  // operands the requester presented then.
  task automatic test_random();
    int exp_id [$];
    logic [7:0] exp_data [$];
    int trig_c [$];
    logic [7:0] a_m [N];
    logic [7:0] b_m [N];
    logic [3:0] req_prev, inflight, exp_ack;
    int ptr_m, j, e, tc, n_acks;
    logic [7:0] ed;
    apply_reset();
    ptr_m = 0; req_prev = '0; inflight = '0; n_acks = 0;
    for (int c = 1; c <= 2000; c++) begin
      tick();
      if (dut.trig_q) begin
        j = -1;
        for (int off = 0; off < N; off++)
          if (j < 0 && req_prev[(ptr_m + off) % N]) j = (ptr_m + off) % N;
        n_checks++; if (j < 0) begin n_fail++; $display("FAIL rand_grant_without_request got=req %b exp=some request", req_prev); end
        else begin
          exp_id.push_back(j);
          exp_data.push_back(prod8(a_m[j], b_m[j]));
          trig_c.push_back(c);
          inflight[j] = 1'b1;
        end
      end
      if (bus.resp_valid) begin
        n_checks++;
        if (exp_id.size() == 0) begin n_fail++; $display("FAIL rand_unexpected_ack got=id %0d exp=no ack", bus.resp_id); end
        else begin
          e = exp_id.pop_front(); ed = exp_data.pop_front(); tc = trig_c.pop_front();
          exp_ack = 4'b0001 << e;
          n_acks++;
          if (bus.resp_id !== 2'(e) || bus.ack !== exp_ack || bus.resp_data !== ed || bus.resp_err !== 1'b0 || c - tc !== lat_l + 1) begin
            n_fail++;
            $display("FAIL rand_ack[%0d] got=id %0d ack %b data %h err %b lat %0d exp=id %0d ack %b data %h err 0 lat %0d",
                     n_acks, bus.resp_id, bus.ack, bus.resp_data, bus.resp_err, c - tc, e, exp_ack, ed, lat_l + 1);
          end
          ptr_m = (e + 1) % N;
          bus.req[e] = 1'b0;
          inflight[e] = 1'b0;
        end
      end
      if (c < 1500) begin
        for (int i = 0; i < N; i++) begin
          if (inflight[i]) begin
            if ($urandom_range(0, 3) == 0) bus.req_a[i*W +: W] = 8'($urandom);
          end else if (!bus.req[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              a_m[i] = 8'($urandom); b_m[i] = 8'($urandom);
              bus.req_a[i*W +: W] = a_m[i]; bus.req_b[i*W +: W] = b_m[i];
              bus.req[i] = 1'b1;
            end
          end else if ($urandom_range(0, 9) == 0) begin
            bus.req[i] = 1'b0;
          end
        end
      end else if (exp_id.size() == 0 && bus.req == 4'b0000 && !bus.busy) begin
        break;
      end
      req_prev = bus.req;
    end
    n_checks++; if (exp_id.size() !== 0 || bus.req !== 4'b0000) begin n_fail++; $display("FAIL rand_drain got=%0d outstanding req %b exp=0 0000", exp_id.size(), bus.req); end
    n_checks++; if (n_acks < 20) begin n_fail++; $display("FAIL rand_activity got=%0d acks exp>=20", n_acks); end
  endtask

  initial begin
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    bus_to.req = '0; bus_to.req_a = '0; bus_to.req_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_withdraw();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
